sync_fifo_param: RTL and testbench

- Single-clock, parametrised FIFO: the next-generation synchronous counterpart of the team's async_fifo_top.
- Used where producer and consumer share one clock, so no gray-code pointer synchronisers are needed.
- Adds behaviour the async FIFO lacks: occupancy count, programmable almost-full/almost-empty, sticky overflow/underflow error flags, and a read-valid strobe.
- Optional first-word-fall-through (FWFT) mode.

---
 rtl/sync_fifo_pkg.sv | 20 ++
 rtl/sync_fifo_param_if.sv | 31 +++
 rtl/sync_fifo_mem.sv | 26 ++
 rtl/sync_fifo_param.sv | 127 ++++++++++++
 tb/tb_sync_fifo_param.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the single-clock parametrised FIFO.
package sync_fifo_pkg;

  localparam int DEF_DEPTH     = 16;
  localparam int DEF_PTRWIDTH  = 4;
  localparam int DEF_DWIDTH    = 8;
  localparam int DEF_AF_THRESH = DEF_DEPTH - 2;
  localparam int DEF_AE_THRESH = 2;

  // Pointer/occupancy type: one extra bit so full and empty stay distinguishable.
  typedef logic [DEF_PTRWIDTH:0] ptr_t;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of sync_fifo_param; master drives requests, slave is the FIFO.
interface sync_fifo_param_if #(
  parameter int DWIDTH   = sync_fifo_pkg::DEF_DWIDTH,
  parameter int PTRWIDTH = sync_fifo_pkg::DEF_PTRWIDTH
);

  logic                push;
  logic [DWIDTH-1:0]   wdata;
  logic                pop;
  logic                clr_err;
  logic [DWIDTH-1:0]   rdata;
  logic                rvalid;
  logic                full;
  logic                almost_full;
  logic                empty;
  logic                almost_empty;
  logic [PTRWIDTH:0]   count;
  logic                overflow;
  logic                underflow;

  modport master (
    output push, wdata, pop, clr_err,
    input  rdata, rvalid, full, almost_full, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  push, wdata, pop, clr_err,
    output rdata, rvalid, full, almost_full, empty, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DWIDTH register file: one synchronous write port, one asynchronous read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int PTRWIDTH = DEF_PTRWIDTH,
  parameter int DWIDTH   = DEF_DWIDTH
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [PTRWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0]   wdata_i,
  input  logic [PTRWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0]   rdata_o
);

  // Storage is deliberately not reset.
  logic [DWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered latency-1 read.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PTRWIDTH  = DEF_PTRWIDTH,
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic             clk,
  input  logic             reset,
  sync_fifo_param_if.slave bus
);

  typedef logic [PTRWIDTH:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AF_C    = cnt_t'(AF_THRESH);
  localparam cnt_t AE_C    = cnt_t'(AE_THRESH);

  if (DEPTH < 2 || DEPTH != (1 << PTRWIDTH) || log2_ceil(DEPTH) != PTRWIDTH
      || AE_THRESH >= AF_THRESH) begin : g_param_err
    $error("sync_fifo_param: DEPTH must be 2**PTRWIDTH (>=2) and AE_THRESH < AF_THRESH");
  end

  cnt_t wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic full_q, full_d, empty_q, empty_d;
  logic af_q, af_d, ae_q, ae_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic pop_ok, wr_ok;
  logic [DWIDTH-1:0] mem_rdata;

  always_comb begin
    pop_ok  = bus.pop & ~empty_q;
    // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
    wr_ok   = bus.push & (~full_q | pop_ok);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok)  wptr_d = wptr_q + cnt_t'(1);
    if (pop_ok) rptr_d = rptr_q + cnt_t'(1);
    if (wr_ok && !pop_ok)      count_d = count_q + cnt_t'(1);
    else if (pop_ok && !wr_ok) count_d = count_q - cnt_t'(1);
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    // A new error beats a simultaneous clear.
    ovf_d   = (bus.push & ~wr_ok) | (ovf_q & ~bus.clr_err);
    unf_d   = (bus.pop & ~pop_ok) | (unf_q & ~bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  sync_fifo_mem #(
    .DEPTH    (DEPTH),
    .PTRWIDTH (PTRWIDTH),
    .DWIDTH   (DWIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok & ~reset),
    .waddr_i (wptr_q[PTRWIDTH-1:0]),
    .wdata_i (bus.wdata),
    .raddr_i (rptr_q[PTRWIDTH-1:0]),
    .rdata_o (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rdata  = mem_rdata;
  assign bus.rvalid = ~empty_q;
`else
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = pop_ok;
    if (pop_ok) rdata_d = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
`endif

  assign bus.full         = full_q;
  assign bus.almost_full  = af_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: queue reference model, random and directed traffic.
module tb_sync_fifo_param;
  import sync_fifo_pkg::*;

  localparam int DEPTH = DEF_DEPTH;
  localparam int AF    = DEF_AF_THRESH;
  localparam int AE    = DEF_AE_THRESH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DWIDTH(DEF_DWIDTH), .PTRWIDTH(DEF_PTRWIDTH)) bus ();

  sync_fifo_param dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit ovf_m, unf_m, rv_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("count",        32'(bus.count),        32'(model_q.size()));
    chk("full",         32'(bus.full),         32'(model_q.size() == DEPTH));
    chk("empty",        32'(bus.empty),        32'(model_q.size() == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(model_q.size() >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(model_q.size() <= AE));
    chk("overflow",     32'(bus.overflow),     32'(ovf_m));
    chk("underflow",    32'(bus.underflow),    32'(unf_m));
`ifdef SYNC_FIFO_FWFT_EN
    chk("rvalid", 32'(bus.rvalid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) chk("rdata_head", 32'(bus.rdata), 32'(model_q[0]));
`else
    chk("rvalid", 32'(bus.rvalid), 32'(rv_m));
`endif
  endtask

  // Drive one cycle of requests, advance the model, then check after the edge.
  task automatic step(input bit p, input logic [7:0] d, input bit q, input bit c);
    bit pop_ok, wr_ok;
    bus.push = p; bus.wdata = d; bus.pop = q; bus.clr_err = c;
    pop_ok = q && (model_q.size() != 0);
    wr_ok  = p && ((model_q.size() < DEPTH) || pop_ok);
    if (p && !wr_ok) ovf_m = 1'b1; else if (c) ovf_m = 1'b0;
    if (q && !pop_ok) unf_m = 1'b1; else if (c) unf_m = 1'b0;
    if (pop_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) begin
      model_q.push_back(d);
      wr_total++;
    end
    rv_m = pop_ok;
    @(posedge clk); #1;
    check_state();
  endtask

  task automatic rst_step(input bit p, input bit q);
    reset = 1'b1;
    bus.push = p; bus.wdata = 8'($urandom); bus.pop = q; bus.clr_err = 1'($urandom_range(0, 1));
    model_q.delete();
    ovf_m = 1'b0; unf_m = 1'b0; rv_m = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_state();
`ifndef SYNC_FIFO_FWFT_EN
    chk("rdata_reset", 32'(bus.rdata), 32'h0);
`endif
  endtask

  // Monitor: every data word the DUT presents is compared against the scoreboard queue.
  always @(negedge clk) begin
`ifdef SYNC_FIFO_FWFT_EN
    if (reset === 1'b0 && bus.pop === 1'b1 && bus.rvalid === 1'b1) begin
`else
    if (bus.rvalid === 1'b1) begin
`endif
      if (exp_q.size() == 0) chk("rvalid_unexpected", 32'(bus.rvalid), 32'h0);
      else chk("rdata", 32'(bus.rdata), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit p, q, c;
    rst_step(1'b0, 1'b0);
    rst_step(1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    step(1'b1, 8'h33, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic in alternating push-heavy and pop-heavy phases; at least three pointer wraps.
    wr_total = 0;
    for (int i = 0; i < 2000 && wr_total < 3 * 2 * DEPTH + 8; i++) begin
      p = ($urandom_range(0, 99) < (((i / 40) % 2) ? 30 : 75));
      q = ($urandom_range(0, 99) < (((i / 40) % 2) ? 75 : 30));
      c = ($urandom_range(0, 99) < 5);
      step(p, 8'($urandom), q, c);
    end
    chk("wrap_coverage", 32'(wr_total >= 3 * 2 * DEPTH), 32'h1);

    for (int i = 0; i < 40 && model_q.size() != 7; i++) begin
      if (model_q.size() < 7) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      else                    step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("count_before_reset", 32'(bus.count), 32'd7);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst_step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
